mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Multiply/divide unit and HI/LO controller for the five-stage pipeline, instantiated in the E stage alongside the ALU.
- Accepts one mult/multu/div/divu/mthi/mtlo command per start pulse.
- Sequences multi-cycle operations with a fixed-latency countdown and owns the HI/LO register pair.
- Drives the hl_busy input of the stall unit, so D-stage HI/LO instructions wait while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset; one clock; polarity and synchronicity fixed
start  in  1  E-stage instruction is a HI/LO writer this cycle; qualifies md_op
md_op  in  3  operation code (package constants)
rs_val  in  32  forwarded rs operand
rt_val  in  32  forwarded rt operand
busy  out  1  operation in flight; wired to stall unit hl_busy
hi  out  32  current HI register
lo  out  32  current LO register

Behaviour:
- Reset: state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending registers=0. Reset wins over a simultaneous start.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE with start and md_op in {MULT, MULTU, DIV, DIVU}:
  - Latch the result into hi_pend/lo_pend at this edge, computed from rs_val/rt_val in the start cycle.
  - Load cnt = MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN: cnt decrements each cycle. On the edge where cnt==1: hi<=hi_pend, lo<=lo_pend, state->IDLE.
- Timing for start in cycle T: busy=1 in cycles T+1..T+N, busy=0 at T+N+1, new hi/lo visible from T+N+1.
- Start in the start cycle itself (busy still 0): the stall unit covers this cycle through its E-stage decode.
- MTHI: hi<=rs_val at the start edge. MTLO: lo<=rs_val. Neither touches busy or state.
- Start while in RUN is a protocol violation; the stall unit prevents it. Required response: command ignored, RUN continues unchanged; bench asserts it never occurs.
- md_op=NONE or an undefined code with start=1: no effect.
- Arithmetic:
  - mult: signed 32x32->64. multu: unsigned 32x32->64. {hi,lo}=product.
  - div: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - divu: unsigned.
  - Divide by zero (rt_val==0): operation still takes DIV_CYCLES and asserts busy; hi/lo unchanged at completion (pending = current hi/lo).
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- hi/lo are register outputs; there is no bypass of pending results before completion.
- Reset mid-RUN: aborts; busy=0, hi=lo=0 on the next cycle.

Decomposition:
- Shared package (mdu_pkg):
  - md_op constants: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - State encodings: IDLE=0, RUN=1.
  - Default latencies.
- Sub-module md_calc: purely combinational, inputs md_op, rs_val, rt_val, hi, lo; outputs hi_res, lo_res. Holds all arithmetic, including the div-by-zero hold. mdu_ctrl keeps the FSM, counter and registers.

Test Plan:
- Reset, then start MULT with rs=0xFFFFFFFD (-3), rt=5 at T -> busy=1 for T+1..T+5, busy=0 at T+6, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU with rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
- DIV with rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO (busy stays 0, values visible next cycle). Then DIVU with rs=7, rt=0 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
- MULT started, reset asserted in the third busy cycle -> next cycle busy=0, hi=lo=0. A later MULT 3*4 completes normally with lo=12, hi=0.
- Back-to-back: second start held off until busy=0, issued in the first IDLE cycle -> second result overwrites the first with no gap error. A start injected during RUN is ignored and the first result is intact.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, latencies.
package mdu_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Countdown width; latencies are limited to 1..15.
  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl_md_calc.sv
// Combinational HI/LO result generator for every md_op; the controller decides when to commit.
module md_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  logic signed [63:0] mul_a_s, mul_b_s, prod_s;
  logic        [63:0] mul_a_u, mul_b_u, prod_u;
  logic signed [32:0] div_a_s, div_b_s, quot_s, rem_s;
  logic        [31:0] div_b_u, quot_u, rem_u;
  logic               div_zero;

  // Operand extension and raw products/quotients; divisor forced non-zero so the
  // dividers never see zero (the result is discarded in that case anyway).
  always_comb begin
    div_zero = (rt_val == 32'd0);
    mul_a_s  = {{32{rs_val[31]}}, rs_val};
    mul_b_s  = {{32{rt_val[31]}}, rt_val};
    prod_s   = mul_a_s * mul_b_s;
    mul_a_u  = {32'd0, rs_val};
    mul_b_u  = {32'd0, rt_val};
    prod_u   = mul_a_u * mul_b_u;
    // 33-bit signed divide keeps 0x80000000 / -1 representable (quotient 2^31 wraps to 0x80000000).
    div_a_s  = {rs_val[31], rs_val};
    div_b_s  = div_zero ? 33'sd1 : {rt_val[31], rt_val};
    quot_s   = div_a_s / div_b_s;
    rem_s    = div_a_s % div_b_s;
    div_b_u  = div_zero ? 32'd1 : rt_val;
    quot_u   = rs_val / div_b_u;
    rem_u    = rs_val % div_b_u;
  end

  // Select the HI/LO pair the operation would produce; unrelated or undefined ops hold.
  always_comb begin
    hi_res = hi;
    lo_res = lo;
    case (md_op)
      MD_MULT:  begin hi_res = prod_s[63:32]; lo_res = prod_s[31:0]; end
      MD_MULTU: begin hi_res = prod_u[63:32]; lo_res = prod_u[31:0]; end
      MD_DIV:   if (!div_zero) begin hi_res = rem_s[31:0]; lo_res = quot_s[31:0]; end
      MD_DIVU:  if (!div_zero) begin hi_res = rem_u; lo_res = quot_u; end
      MD_MTHI:  hi_res = rs_val;
      MD_MTLO:  lo_res = rs_val;
      default:  ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO controller: fixed-latency countdown for mult/div, immediate mthi/mtlo, owns HI/LO.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
  logic [31:0]      hi_res, lo_res;

  md_calc u_calc (
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi     (hi_q),
    .lo     (lo_q),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  // Next-state logic: results are captured at start into the pending pair and only
  // committed to HI/LO on the last countdown edge; starts during RUN are ignored.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              hi_pend_d = hi_res;
              lo_pend_d = lo_res;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              hi_pend_d = hi_res;
              lo_pend_d = lo_res;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = ST_RUN;
            end
            MD_MTHI, MD_MTLO: begin
              hi_d = hi_res;
              lo_d = lo_res;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = hi_pend_q;
          lo_d    = lo_pend_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and HI/LO registers; reset clears everything and aborts a running op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_pend_q <= '0;
      lo_pend_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: a timeline reference model predicts busy/hi/lo each cycle.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        busy;
  logic [31:0] hi, lo;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: cycle index and the last cycle in which an operation keeps busy high.
  int          cyc     = 0;
  int          run_end = -1;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;

  function automatic void calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    rh = m_hi;
    rl = m_lo;
    if (op == MD_MULT) begin
      p = sa * sb; rh = p[63:32]; rl = p[31:0];
    end else if (op == MD_MULTU) begin
      p = ua * ub; rh = p[63:32]; rl = p[31:0];
    end else if (op == MD_DIV && b != 0) begin
      sq = sa / sb; sr = sa % sb;
      p = sq; rl = p[31:0];
      p = sr; rh = p[31:0];
    end else if (op == MD_DIVU && b != 0) begin
      rl = a / b; rh = a % b;
    end
  endfunction

  // Apply one cycle of inputs, then advance the model across that edge and queue the
  // expected outputs for the cycle that follows.
  task automatic drive(input logic r, input logic s, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    bit running;
    reset = r; start = s; md_op = op; rs_val = a; rt_val = b;
    @(posedge clk);
    #1;
    running = (cyc <= run_end);
    if (r) begin
      m_hi = 0; m_lo = 0; run_end = -1;
    end else if (running) begin
      if (cyc == run_end) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (s) begin
      if (op == MD_MULT || op == MD_MULTU) begin
        calc(op, a, b, p_hi, p_lo); run_end = cyc + MULT_N;
      end else if (op == MD_DIV || op == MD_DIVU) begin
        calc(op, a, b, p_hi, p_lo); run_end = cyc + DIV_N;
      end else if (op == MD_MTHI) m_hi = a;
      else if (op == MD_MTLO) m_lo = a;
    end
    cyc++;
    exp_q.push_back('{busy: (cyc <= run_end), hi: m_hi, lo: m_lo});
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, MD_NONE, $urandom, $urandom);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20 && cyc <= run_end; k++) idle();
    idle();
  endtask

  task automatic cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(1'b0, 1'b1, op, a, b);
  endtask

  // Monitor: compare DUT outputs against the queued expectations away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (busy !== e.busy) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, e.busy);
      end
      total++;
      if (hi !== e.hi) begin
        bad++;
        $display("FAIL hi cyc=%0d got=%08h want=%08h", cyc, hi, e.hi);
      end
      total++;
      if (lo !== e.lo) begin
        bad++;
        $display("FAIL lo cyc=%0d got=%08h want=%08h", cyc, lo, e.lo);
      end
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    drive(1'b1, 1'b1, MD_MULT, 32'd3, 32'd4);
    drive(1'b1, 1'b0, MD_NONE, 32'd0, 32'd0);

    cmd(MD_MULT, 32'hFFFF_FFFD, 32'd5);            wait_done();
    cmd(MD_MULTU, 32'hFFFF_FFFF, 32'd2);           wait_done();
    cmd(MD_DIV, 32'hFFFF_FFF9, 32'd2);             wait_done();
    cmd(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);     wait_done();
    cmd(MD_MTHI, 32'h11, 32'h99);
    cmd(MD_MTLO, 32'h22, 32'h99);
    idle();
    cmd(MD_DIVU, 32'd7, 32'd0);                    wait_done();
    cmd(MD_DIV, 32'd7, 32'd0);                     wait_done();
    cmd(MD_NONE, 32'h55, 32'h66);
    cmd(3'd7, 32'h55, 32'h66);

    // Reset in the third busy cycle aborts the multiply.
    cmd(MD_MULT, 32'd100, 32'd100);
    idle(); idle();
    drive(1'b1, 1'b0, MD_NONE, 32'd0, 32'd0);
    cmd(MD_MULT, 32'd3, 32'd4);                    wait_done();

    // Back-to-back: second start in the first IDLE cycle.
    cmd(MD_MULT, 32'd6, 32'd7);
    for (int k = 0; k < 20 && cyc <= run_end; k++) idle();
    cmd(MD_DIVU, 32'd100, 32'd7);                  wait_done();

    // Start injected during RUN is ignored.
    cmd(MD_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    idle();
    cmd(MD_DIV, 32'd50, 32'd5);
    cmd(MD_MTHI, 32'hAAAA_AAAA, 32'd0);
    wait_done();

    // Randomized traffic including starts during RUN, zero divisors and rare resets.
    for (int i = 0; i < 600; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15)) - 32'd8;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), op, a, b);
    end
    wait_done();
    idle();

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
